sms_audio_mixer: RTL and testbench
==================================

# sms_audio_mixer

Downstream audio stage of the SMS board: consumes the YM2413 multiplexed outputs (`opll_mo`, `opll_ro`) and the VDP PSG level (`vdp_psg`), box-filters and decimates them to one sample per 1024 MCLK cycles (~52.4 kHz at 53.69 MHz), and mixes them into the 18-bit `aud_l`/`aud_r` board outputs. It also implements the I/O port $F2 audio-control register on the Z80 bus, which selects PSG, FM, both or mute.

## Interface
- `WIN_LOG2`, 10: log2 of the decimation window in MCLK cycles.
- `FM_SHIFT`, 6: left shift applied to the averaged FM sample before mixing.
- `FM_PRESENT`, 1: 1 = port $F2 is readable and writable; 0 = the port never drives the bus, the register holds 2'b00 (PSG only).

Ports:
- `MCLK`  in  1  system clock; all state changes on the rising edge.
- `ext_reset`  in  1  reset, synchronous, active-high.
- `ADDRESS`  in  8  Z80 address bus, low byte.
- `DATA_i`  in  8  Z80 data bus.
- `IORQ`, `RD`, `WR`  in  1 each  Z80 strobes, active-low.
- `DATA_o`  out  8  read data for port $F2.
- `DATA_d`  out  1  active-low data-bus drive enable.
- `opll_mo`, `opll_ro`  in  10 each  YM2413 melody/rhythm outputs, unsigned offset binary, midpoint 512.
- `vdp_psg`  in  16  PSG level, unsigned, 0 = silence.
- `aud_l`, `aud_r`  out  18  signed mixed sample; both carry the same value (mono).
- `sample_valid`  out  1  one-cycle pulse when `aud_l`/`aud_r` update.

## Operation
- Control register `mode[1:0]`:
  - 00 = PSG only.
  - 01 = FM only.
  - 10 = mute.
  - 11 = PSG + FM.
- Write: registered `WR_q` = 1 and `WR` = 0 (falling edge), with `IORQ` = 0 and `ADDRESS` = $F2, loads `mode` <= `DATA_i[1:0]`.
  - Exactly one load per WR pulse, however long WR stays low.
  - Ignored when `FM_PRESENT` = 0.
- Read: `IORQ` = 0, `RD` = 0, `ADDRESS` = $F2 and `FM_PRESENT` = 1 gives `DATA_d` = 0 and `DATA_o` = {6'h00, `mode`}. This is combinational from the bus inputs and the `mode` register. Otherwise `DATA_d` = 1 and `DATA_o` = 8'h00.
- FM sample per MCLK: `f = opll_mo + opll_ro - 1024`, 11-bit signed, range -1024..+1022.
- Window counter `cnt` is WIN_LOG2 bits and increments every cycle, wrapping from 1023 to 0.
- `acc_fm` (21-bit signed) and `acc_psg` (26-bit unsigned) accumulate `f` and `vdp_psg` every cycle.
- On the cycle where `cnt` = 1023:
  - Compute the window totals `tot_fm = acc_fm + f` and `tot_psg = acc_psg + vdp_psg`.
  - `fm_avg = tot_fm >>> WIN_LOG2`, arithmetic shift, 11-bit.
  - `psg_avg = tot_psg >> WIN_LOG2`, 16-bit.
  - `fm_term = fm_avg <<< FM_SHIFT`, sign-extended to 19 bits; forced to 0 when `mode[0]` = 0.
  - `psg_term = {3'b000, psg_avg}`; forced to 0 unless `mode` is 00 or 11.
  - `mix = fm_term + psg_term`, computed at 19 bits.
  - `mix` saturates to [-131072, +131071] and is registered into `aud_l`/`aud_r`.
  - Both accumulators reload to 0 for the next window.
- The `mode` value used is the one registered at the start of that cycle. A write on the same cycle takes effect from the next window.

## Timing
- Reset values, including reset asserted mid-window:
  - `cnt`, `acc_fm`, `acc_psg` = 0.
  - `mode` = 2'b00.
  - `aud_l` = `aud_r` = 0, `sample_valid` = 0.
  - `WR_q` = 1.
  - The partial window is discarded.
- First `cnt` = 1023 occurs 1023 cycles after the cycle in which `ext_reset` was sampled low.
- Output latency: `aud_*` and `sample_valid` = 1 appear on the edge that ends the `cnt` = 1023 cycle. `sample_valid` is high for exactly one cycle out of every 1024.
- `aud_*` hold their value between pulses.
- Register write latency: `mode` updates on the edge where the WR falling edge is sampled. A read in the following cycle returns the new value.

## Test plan
- Reset, `opll_mo` = `opll_ro` = 512, `vdp_psg` = 0, mode 00 -> first `sample_valid` after 1024 cycles; `aud_l` = `aud_r` = 0; pulses exactly 1024 cycles apart.
- Write $03 to port $F2; `mo` = `ro` = 1023 (f = +1022), `psg` = 16'hFFFF -> fm_term = 65408, psg_term = 65535, `aud` = 130943. With `mo` = `ro` = 0 -> `aud` = -65536 + 65535 = -1.
- Mode 01, `mo` = `ro` = 0 (f = -1024), `psg` = 16'hFFFF -> `aud` = -65536; mode 10 -> `aud` = 0; mode 00 with the same inputs -> `aud` = 65535.
- Hold WR low for 20 cycles while writing $01, then read $F2 -> one register load; `DATA_d` = 0, `DATA_o` = $01. Read $F3 -> `DATA_d` = 1. With `FM_PRESENT` = 0, a read of $F2 -> `DATA_d` = 1 and mode stays 00.
- Alternate f = +1022 and f = -1024 every cycle -> averaged `fm_avg` = -1, `aud` = -64 in mode 01, showing the box-filter average with arithmetic shift.
- Assert `ext_reset` at `cnt` = 500 with non-zero accumulators -> outputs 0 and mode 00 on the next edge; the next sample reflects only post-reset inputs.

Source files
------------

// File: rtl/sms_audio_mixer.sv
// SMS board audio back end: box-filters and decimates the YM2413 and PSG levels
// to one sample per 2**WIN_LOG2 clocks, mixes them and owns the port $F2 control register.
module sms_audio_mixer #(
  parameter int WIN_LOG2   = 10,
  parameter int FM_SHIFT   = 6,
  parameter int FM_PRESENT = 1
) (
  input  logic        MCLK,
  input  logic        ext_reset,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  DATA_i,
  input  logic        IORQ,
  input  logic        RD,
  input  logic        WR,
  output logic [7:0]  DATA_o,
  output logic        DATA_d,
  input  logic [9:0]  opll_mo,
  input  logic [9:0]  opll_ro,
  input  logic [15:0] vdp_psg,
  output logic [17:0] aud_l,
  output logic [17:0] aud_r,
  output logic        sample_valid
);

  localparam int  AFW   = 11 + WIN_LOG2;
  localparam int  APW   = 16 + WIN_LOG2;
  localparam bit  FM_EN = (FM_PRESENT != 0);

  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic signed [AFW-1:0] acc_fm_q, acc_fm_d;
  logic [APW-1:0]        acc_psg_q, acc_psg_d;
  logic [1:0]            mode_q, mode_d;
  logic                  wr_q, wr_d;
  logic [17:0]           aud_q, aud_d;
  logic                  sample_valid_q, sample_valid_d;

  logic [10:0]           fm_sum_s;
  logic signed [10:0]    f_s;
  logic signed [AFW-1:0] tot_fm_s;
  logic [APW-1:0]        tot_psg_s;
  logic signed [10:0]    fm_avg_s;
  logic [15:0]           psg_avg_s;
  logic signed [18:0]    fm_term_s;
  logic signed [18:0]    psg_term_s;
  logic signed [18:0]    mix_s;
  logic [17:0]           mix_sat_s;
  logic                  win_end_s;
  logic                  wr_fall_s;
  logic                  rd_sel_s;
  logic                  unused_data_s;

  // Window accumulation, averaging, mixing and control-register next state
  always_comb begin
    fm_sum_s   = {1'b0, opll_mo} + {1'b0, opll_ro};
    f_s        = signed'(fm_sum_s - 11'd1024);
    tot_fm_s   = acc_fm_q + {{(AFW-11){f_s[10]}}, f_s};
    tot_psg_s  = acc_psg_q + {{(APW-16){1'b0}}, vdp_psg};
    // Upper bits of the signed total are the floor (arithmetic-shift) average
    fm_avg_s   = tot_fm_s[AFW-1:WIN_LOG2];
    psg_avg_s  = tot_psg_s[APW-1:WIN_LOG2];
    win_end_s  = &cnt_q;

    if (mode_q[0]) begin
      fm_term_s = signed'({{8{fm_avg_s[10]}}, fm_avg_s}) <<< FM_SHIFT;
    end else begin
      fm_term_s = 19'sd0;
    end

    if ((mode_q == 2'b00) || (mode_q == 2'b11)) begin
      psg_term_s = signed'({3'b000, psg_avg_s});
    end else begin
      psg_term_s = 19'sd0;
    end

    mix_s = fm_term_s + psg_term_s;
    if (mix_s[18] != mix_s[17]) begin
      mix_sat_s = mix_s[18] ? 18'h20000 : 18'h1FFFF;
    end else begin
      mix_sat_s = mix_s[17:0];
    end

    cnt_d = cnt_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};
    if (win_end_s) begin
      acc_fm_d       = '0;
      acc_psg_d      = '0;
      aud_d          = mix_sat_s;
      sample_valid_d = 1'b1;
    end else begin
      acc_fm_d       = tot_fm_s;
      acc_psg_d      = tot_psg_s;
      aud_d          = aud_q;
      sample_valid_d = 1'b0;
    end

    wr_d      = WR;
    wr_fall_s = wr_q & ~WR & ~IORQ & (ADDRESS == 8'hF2);
    if (!FM_EN) begin
      mode_d = 2'b00;
    end else if (wr_fall_s) begin
      mode_d = DATA_i[1:0];
    end else begin
      mode_d = mode_q;
    end
  end

  // Port $F2 read path, combinational from the bus strobes
  always_comb begin
    rd_sel_s = FM_EN & ~IORQ & ~RD & (ADDRESS == 8'hF2);
    DATA_d   = ~rd_sel_s;
    if (rd_sel_s) begin
      DATA_o = {6'h00, mode_q};
    end else begin
      DATA_o = 8'h00;
    end
  end

  assign unused_data_s = ^DATA_i[7:2];

  // State registers with synchronous reset; a reset discards the partial window
  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      cnt_q          <= '0;
      acc_fm_q       <= '0;
      acc_psg_q      <= '0;
      mode_q         <= 2'b00;
      wr_q           <= 1'b1;
      aud_q          <= 18'h00000;
      sample_valid_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      acc_fm_q       <= acc_fm_d;
      acc_psg_q      <= acc_psg_d;
      mode_q         <= mode_d;
      wr_q           <= wr_d;
      aud_q          <= aud_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign aud_l        = aud_q;
  assign aud_r        = aud_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sms_audio_mixer.sv
// Bench for sms_audio_mixer: randomized and directed inputs scored against a per-window
// arithmetic model; a second instance covers the FM-absent build.
module tb_sms_audio_mixer;

  logic        MCLK = 1'b0;
  logic        ext_reset = 1'b1;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  DATA_i = 8'h00;
  logic        IORQ = 1'b1, RD = 1'b1, WR = 1'b1;
  logic [9:0]  opll_mo = 10'd512, opll_ro = 10'd512;
  logic [15:0] vdp_psg = 16'h0000;
  logic [7:0]  DATA_o, DATA_o1;
  logic        DATA_d, DATA_d1;
  logic [17:0] aud_l, aud_r, aud_l1, aud_r1;
  logic        sample_valid, sample_valid1;

  sms_audio_mixer #(.WIN_LOG2(10), .FM_SHIFT(6), .FM_PRESENT(1)) u_dut (
    .MCLK(MCLK), .ext_reset(ext_reset), .ADDRESS(ADDRESS), .DATA_i(DATA_i),
    .IORQ(IORQ), .RD(RD), .WR(WR), .DATA_o(DATA_o), .DATA_d(DATA_d),
    .opll_mo(opll_mo), .opll_ro(opll_ro), .vdp_psg(vdp_psg),
    .aud_l(aud_l), .aud_r(aud_r), .sample_valid(sample_valid));

  sms_audio_mixer #(.WIN_LOG2(10), .FM_SHIFT(6), .FM_PRESENT(0)) u_nofm (
    .MCLK(MCLK), .ext_reset(ext_reset), .ADDRESS(ADDRESS), .DATA_i(DATA_i),
    .IORQ(IORQ), .RD(RD), .WR(WR), .DATA_o(DATA_o1), .DATA_d(DATA_d1),
    .opll_mo(opll_mo), .opll_ro(opll_ro), .vdp_psg(vdp_psg),
    .aud_l(aud_l1), .aud_r(aud_r1), .sample_valid(sample_valid1));

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int failures = 0;

  // reference model state
  int       cyc;
  longint   sum_f, sum_p;
  bit [1:0] mode_m;
  bit       wr_prev;
  bit       end_of_win;
  int       exp_aud, exp_aud0;
  int       stray;
  int       pat;
  logic [9:0]  c_mo, c_ro;
  logic [15:0] c_psg;

  function automatic int mix_model(longint sf, longint sp, bit [1:0] m);
    longint fa, pa, mx;
    fa = sf >>> 10;
    pa = sp >>> 10;
    mx = (m[0] ? fa * 64 : 0) + ((m == 2'b00 || m == 2'b11) ? pa : 0);
    if (mx > 131071) mx = 131071;
    if (mx < -131072) mx = -131072;
    return int'(mx);
  endfunction

  task automatic tick();
    case (pat)
      0: begin opll_mo = c_mo; opll_ro = c_ro; vdp_psg = c_psg; end
      1: begin
        opll_mo = (cyc % 2 == 0) ? 10'd1023 : 10'd0;
        opll_ro = (cyc % 2 == 0) ? 10'd1023 : 10'd0;
        vdp_psg = c_psg;
      end
      default: begin
        opll_mo = 10'($urandom_range(0, 1023));
        opll_ro = 10'($urandom_range(0, 1023));
        vdp_psg = 16'($urandom_range(0, 65535));
      end
    endcase
    sum_f += longint'(opll_mo) + longint'(opll_ro) - 1024;
    sum_p += longint'(vdp_psg);
    end_of_win = (cyc == 1023);
    if (end_of_win) begin
      exp_aud  = mix_model(sum_f, sum_p, mode_m);
      exp_aud0 = mix_model(sum_f, sum_p, 2'b00);
      sum_f = 0;
      sum_p = 0;
    end
    if (wr_prev && !WR && !IORQ && ADDRESS == 8'hF2) mode_m = DATA_i[1:0];
    wr_prev = WR;
    @(posedge MCLK); #1;
    cyc = (cyc + 1) % 1024;
    if (!end_of_win && (sample_valid || sample_valid1)) stray++;
  endtask

  task automatic do_reset();
    ext_reset = 1'b1;
    @(posedge MCLK); #1;
    ext_reset = 1'b0;
    cyc = 0; sum_f = 0; sum_p = 0; mode_m = 2'b00; wr_prev = 1'b1; stray = 0;
  endtask

  task automatic run_to_sample(output int ncyc);
    ncyc = 0;
    do begin
      tick();
      ncyc++;
    end while (!end_of_win && ncyc < 1100);
  endtask

  task automatic write_reg(input logic [7:0] v, input int hold);
    ADDRESS = 8'hF2; DATA_i = v; IORQ = 1'b0; WR = 1'b0;
    repeat (hold) tick();
    WR = 1'b1; IORQ = 1'b1; ADDRESS = 8'h00; DATA_i = 8'h00;
    tick();
  endtask

  task automatic read_port(input logic [7:0] a, output logic [7:0] o, output logic d,
                           output logic [7:0] o1, output logic d1);
    ADDRESS = a; IORQ = 1'b0; RD = 1'b0;
    #1;
    o = DATA_o; d = DATA_d; o1 = DATA_o1; d1 = DATA_d1;
    RD = 1'b1; IORQ = 1'b1; ADDRESS = 8'h00;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] o, o1; logic d, d1; int n;
    pat = 0; c_mo = 10'd512; c_ro = 10'd512; c_psg = 16'h0000;
    do_reset();
    checks++;
    if (aud_l !== 18'h0 || aud_r !== 18'h0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: aud_l=%0h aud_r=%0h sv=%0b required 0 0 0", aud_l, aud_r, sample_valid);
    end
    checks++;
    if (DATA_d !== 1'b1 || DATA_o !== 8'h00) begin
      failures++;
      $display("FAIL idle_bus: DATA_d=%0b DATA_o=%0h required 1 00", DATA_d, DATA_o);
    end
    read_port(8'hF2, o, d, o1, d1);
    checks++;
    if (d !== 1'b0 || o !== 8'h00) begin
      failures++;
      $display("FAIL reset_mode_read: DATA_d=%0b DATA_o=%0h required 0 00", d, o);
    end
    for (int w = 0; w < 2; w++) begin
      run_to_sample(n);
      checks++;
      if (n !== 1024 || sample_valid !== 1'b1 || aud_l !== 18'h0 || aud_r !== 18'h0) begin
        failures++;
        $display("FAIL idle_window%0d: cycles=%0d sv=%0b aud=%0h required 1024 1 0", w, n, sample_valid, aud_l);
      end
    end
    tick();
    checks++;
    if (sample_valid !== 1'b0 || aud_l !== 18'h0 || stray !== 0) begin
      failures++;
      $display("FAIL pulse_width: sv=%0b aud=%0h stray=%0d required 0 0 0", sample_valid, aud_l, stray);
    end
  endtask

  task automatic check_window(input string name);
    int n;
    run_to_sample(n);
    checks++;
    if (sample_valid !== 1'b1 || aud_l !== 18'(exp_aud) || aud_r !== 18'(exp_aud)) begin
      failures++;
      $display("FAIL %s: sv=%0b aud_l=%0d aud_r=%0d required 1 %0d", name, sample_valid,
               $signed(aud_l), $signed(aud_r), exp_aud);
    end
    checks++;
    if (sample_valid1 !== 1'b1 || aud_l1 !== 18'(exp_aud0)) begin
      failures++;
      $display("FAIL %s_nofm: sv=%0b aud=%0d required 1 %0d", name, sample_valid1, $signed(aud_l1), exp_aud0);
    end
  endtask

  task automatic test_mix_both();
    logic [7:0] o, o1; logic d, d1;
    write_reg(8'h03, 1);
    read_port(8'hF2, o, d, o1, d1);
    checks++;
    if (d !== 1'b0 || o !== 8'h03 || d1 !== 1'b1 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL read_mode3: d=%0b o=%0h d1=%0b o1=%0h required 0 03 1 00", d, o, d1, o1);
    end
    pat = 0; c_mo = 10'd1023; c_ro = 10'd1023; c_psg = 16'hFFFF;
    check_window("both_partial");
    check_window("both_max");
    c_mo = 10'd0; c_ro = 10'd0;
    check_window("both_min");
  endtask

  task automatic test_modes();
    pat = 0; c_mo = 10'd0; c_ro = 10'd0; c_psg = 16'hFFFF;
    write_reg(8'h01, 1);
    check_window("fm_partial");
    check_window("fm_only");
    write_reg(8'h02, 1);
    check_window("mute_partial");
    check_window("mute");
    write_reg(8'h00, 1);
    check_window("psg_partial");
    check_window("psg_only");
  endtask

  task automatic test_long_wr();
    logic [7:0] o, o1; logic d, d1;
    ADDRESS = 8'hF2; DATA_i = 8'h01; IORQ = 1'b0; WR = 1'b0;
    tick();
    DATA_i = 8'h02;
    repeat (19) tick();
    WR = 1'b1; IORQ = 1'b1; ADDRESS = 8'h00; DATA_i = 8'h00;
    tick();
    read_port(8'hF2, o, d, o1, d1);
    checks++;
    if (d !== 1'b0 || o !== 8'h01) begin
      failures++;
      $display("FAIL long_wr_read: DATA_d=%0b DATA_o=%0h required 0 01", d, o);
    end
    checks++;
    if (d1 !== 1'b1 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL nofm_read: DATA_d=%0b DATA_o=%0h required 1 00", d1, o1);
    end
    read_port(8'hF3, o, d, o1, d1);
    checks++;
    if (d !== 1'b1 || o !== 8'h00) begin
      failures++;
      $display("FAIL read_f3: DATA_d=%0b DATA_o=%0h required 1 00", d, o);
    end
  endtask

  task automatic test_alternate();
    pat = 1; c_psg = 16'h0000;
    check_window("alt_partial");
    check_window("alt_avg");
  endtask

  task automatic test_random();
    write_reg(8'h03, 1);
    pat = 2;
    for (int i = 0; i < 4; i++) check_window("rand_both");
    write_reg(8'h01, 1);
    check_window("rand_fm_partial");
    check_window("rand_fm");
  endtask

  task automatic test_mid_reset();
    logic [7:0] o, o1; logic d, d1; int n;
    write_reg(8'h03, 1);
    pat = 2;
    n = 0;
    while (cyc != 500 && n < 2100) begin tick(); n++; end
    do_reset();
    checks++;
    if (aud_l !== 18'h0 || aud_r !== 18'h0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_out: aud=%0h sv=%0b required 0 0", aud_l, sample_valid);
    end
    read_port(8'hF2, o, d, o1, d1);
    checks++;
    if (d !== 1'b0 || o !== 8'h00) begin
      failures++;
      $display("FAIL midreset_mode: DATA_d=%0b DATA_o=%0h required 0 00", d, o);
    end
    check_window("post_reset");
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL stray_pulses: count=%0d required 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_mix_both();
    test_modes();
    test_long_wr();
    test_alternate();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
